// File: rtl/adc_capture.sv
// Serial capture engine for the dual-channel 14-bit ADC: start pulse, 34-bit SCK frame, A/B deserialisation.
// Optional sticky trig-while-busy flag on port `overrun` when ADC_CAPTURE_OVERRUN_EN is defined.
`timescale 1ns/1ps

module adc_capture #(
    parameter int SCK_DIV = 2
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        trig,
    output logic        done,
    output logic        busy,
    output logic [13:0] adc_a,
    output logic [13:0] adc_b,
    output logic        ad_conv,
    output logic        spi_sck,
    input  logic        spi_miso
`ifdef ADC_CAPTURE_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam int                DIV_W    = $clog2(2 * SCK_DIV);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(SCK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(2 * SCK_DIV - 1);
    localparam logic [5:0]        BIT_LAST = 6'd33;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic              sck_d;
    logic [5:0]        bit_q;
    logic [13:0]       sh_a_q;
    logic [13:0]       sh_b_q;
    logic [13:0]       adc_a_q;
    logic [13:0]       adc_b_q;
    logic              done_q;
    logic              busy_q;
    logic              ad_conv_q;
    logic              spi_sck_q;
`ifdef ADC_CAPTURE_OVERRUN_EN
    logic              overrun_q;
`endif

    // Next divider count and the SCK level that count implies (high in the second half-period).
    always_comb begin
        div_d = div_q + DIV_W'(1);
        sck_d = (div_d >= DIV_HALF);
    end

    // Frame sequencer: conversion pulse, SCK generation, MISO sampling on the rising half, result copy.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= 6'd0;
            sh_a_q    <= 14'h0000;
            sh_b_q    <= 14'h0000;
            adc_a_q   <= 14'h0000;
            adc_b_q   <= 14'h0000;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ad_conv_q <= 1'b0;
            spi_sck_q <= 1'b0;
`ifdef ADC_CAPTURE_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            ad_conv_q <= 1'b0;
`ifdef ADC_CAPTURE_OVERRUN_EN
            if (trig && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    spi_sck_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (trig) begin
                        state_q   <= S_CONV;
                        ad_conv_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_CONV: begin
                    div_q     <= '0;
                    bit_q     <= 6'd0;
                    sh_a_q    <= 14'h0000;
                    sh_b_q    <= 14'h0000;
                    spi_sck_q <= 1'b0;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    // First high cycle of SCK: data settled since the previous falling edge.
                    if (div_q == DIV_HALF) begin
                        if ((bit_q >= 6'd2) && (bit_q <= 6'd15)) begin
                            sh_a_q <= {sh_a_q[12:0], spi_miso};
                        end
                        if ((bit_q >= 6'd18) && (bit_q <= 6'd31)) begin
                            sh_b_q <= {sh_b_q[12:0], spi_miso};
                        end
                    end
                    if (div_q == DIV_LAST) begin
                        div_q     <= '0;
                        spi_sck_q <= 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            adc_a_q <= sh_a_q;
                            adc_b_q <= sh_b_q;
                        end else begin
                            bit_q <= bit_q + 6'd1;
                        end
                    end else begin
                        div_q     <= div_d;
                        spi_sck_q <= sck_d;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    spi_sck_q <= 1'b0;
                end
            endcase
        end
    end

    assign done    = done_q;
    assign busy    = busy_q;
    assign adc_a   = adc_a_q;
    assign adc_b   = adc_b_q;
    assign ad_conv = ad_conv_q;
    assign spi_sck = spi_sck_q;
`ifdef ADC_CAPTURE_OVERRUN_EN
    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: cycle-arithmetic reference model, per-cycle compare, directed literals.
`timescale 1ns/1ps

module tb_adc_capture;

    localparam int D = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic        miso = 1'b0;
    logic        done, busy, ad_conv, sck;
    logic [13:0] adc_a, adc_b;

    logic        trig1 = 1'b0;
    logic        miso1 = 1'b0;
    logic        done1, busy1, ad_conv1, sck1;
    logic [13:0] adc_a1, adc_b1;
`ifdef ADC_CAPTURE_OVERRUN_EN
    logic        ovr, ovr1;
`endif

    adc_capture #(.SCK_DIV(D)) u_dut (
        .CLK50MHZ(clk), .RST(rst), .trig(trig), .done(done), .busy(busy),
        .adc_a(adc_a), .adc_b(adc_b), .ad_conv(ad_conv), .spi_sck(sck), .spi_miso(miso)
`ifdef ADC_CAPTURE_OVERRUN_EN
        , .overrun(ovr)
`endif
    );

    adc_capture #(.SCK_DIV(1)) u_dut1 (
        .CLK50MHZ(clk), .RST(rst), .trig(trig1), .done(done1), .busy(busy1),
        .adc_a(adc_a1), .adc_b(adc_b1), .ad_conv(ad_conv1), .spi_sck(sck1), .spi_miso(miso1)
`ifdef ADC_CAPTURE_OVERRUN_EN
        , .overrun(ovr1)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame bit j as the converter presents it
    function automatic logic fbit(input int j, input logic [13:0] a, input logic [13:0] b,
                                  input logic [5:0] ign);
        if (j >= 2 && j <= 15) return a[15 - j];
        else if (j >= 18 && j <= 31) return b[31 - j];
        else return ign[j % 6];
    endfunction

    // ---------------- reference model (cycle arithmetic) ----------------
    int          cyc = 0;
    bit          acc_valid = 1'b0;
    int          acc_t = 0;
    int          done_t = 0;
    logic [13:0] pend_a = 14'h0, pend_b = 14'h0, exp_a = 14'h0, exp_b = 14'h0;
    logic [5:0]  pend_ign = 6'h3F;
    logic [13:0] next_a = 14'h0, next_b = 14'h0;
    logic [5:0]  next_ign = 6'h3F;
    bit          ovr_exp = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            acc_valid = 1'b0;
            exp_a     = 14'h0;
            exp_b     = 14'h0;
            ovr_exp   = 1'b0;
        end else if (trig) begin
            if (!acc_valid || cyc > done_t) begin
                acc_valid = 1'b1;
                acc_t     = cyc;
                done_t    = cyc + 2 + 68 * D;
                pend_a    = next_a;
                pend_b    = next_b;
                pend_ign  = next_ign;
            end else begin
                ovr_exp = 1'b1;
            end
        end
        cyc++;
        if (acc_valid && cyc == done_t) begin
            exp_a = pend_a;
            exp_b = pend_b;
        end
    end

    // ---------------- converter models ----------------
    int   idx = 0, idx1 = 0;
    logic sp = 1'b0, sp1 = 1'b0;

    always @(posedge clk) begin
        #1;
        if (ad_conv) idx = 0;
        else if (sp && !sck) idx++;
        sp = sck;
        miso = fbit(idx, pend_a, pend_b, pend_ign);
        if (ad_conv1) idx1 = 0;
        else if (sp1 && !sck1) idx1++;
        sp1 = sck1;
        miso1 = fbit(idx1, 14'h2ABC, 14'h1555, 6'h3F);
    end

    // ---------------- per-cycle compare ----------------
    int   rise_cnt = 0, conv_cnt = 0, done_cnt = 0;
    logic sck_prev = 1'b0;
    logic e_done, e_busy, e_conv, e_sck;
    int   off;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            e_done = 1'b0; e_busy = 1'b0; e_conv = 1'b0; e_sck = 1'b0;
            if (acc_valid) begin
                e_conv = (cyc == acc_t + 1);
                e_busy = (cyc >= acc_t + 1) && (cyc <= done_t);
                e_done = (cyc == done_t);
                off    = cyc - acc_t - 2;
                e_sck  = (off >= 0) && (off < 68 * D) && ((off % (2 * D)) >= D);
            end
            chk("cycle {done,busy,ad_conv,sck,adc_a,adc_b}",
                {32'h0, done, busy, ad_conv, sck, adc_a, adc_b},
                {32'h0, e_done, e_busy, e_conv, e_sck, exp_a, exp_b});
`ifdef ADC_CAPTURE_OVERRUN_EN
            chk("overrun", ovr, ovr_exp);
`endif
        end
        if (sck && !sck_prev) rise_cnt++;
        if (ad_conv) conv_cnt++;
        if (done) done_cnt++;
        sck_prev = sck;
    end

    // ---------------- stimulus ----------------
    task automatic pulse();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) chk("done timeout", 64'd0, 64'd1);
    endtask

    task automatic do_frame(input logic [13:0] a, input logic [13:0] b, input logic [5:0] ign);
        int t0, r0, c0, dc;
        next_a = a; next_b = b; next_ign = ign;
        r0 = rise_cnt; c0 = conv_cnt; t0 = cyc;
        pulse();
        wait_done(dc);
        chk("done latency", 64'(dc - t0), 64'd138);
        chk("adc_a frame", adc_a, a);
        chk("adc_b frame", adc_b, b);
        chk("sck rises", 64'(rise_cnt - r0), 64'd34);
        chk("ad_conv cycles", 64'(conv_cnt - c0), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, d0, d1, d2, tr, prev_rise, rises;
        bit spacing_ok;
        logic p1;

        repeat (3) @(negedge clk);
        chk("reset adc_a", adc_a, 14'h0000);
        chk("reset busy", busy, 1'b0);
        chk("reset sck", sck, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic capture and sign/extreme values
        do_frame(14'h2ABC, 14'h1555, 6'h3F);
        do_frame(14'h2000, 14'h1FFF, 6'h00);
        repeat (20) @(negedge clk);
        chk("hold adc_a", adc_a, 14'h2000);
        chk("hold adc_b", adc_b, 14'h1FFF);
        do_frame(14'h3FFF, 14'h0000, 6'h2A);

        // trig while busy, and again in the DONE cycle
        next_a = 14'h0F0F; next_b = 14'h30C3;
        d0 = done_cnt; t0 = cyc;
        pulse();
        while (cyc < t0 + 50) @(negedge clk);
        pulse();
        while (cyc < t0 + 138) @(negedge clk);
        chk("done in DONE cycle", done, 1'b1);
        pulse();
        repeat (20) @(negedge clk);
        chk("single done for busy trigs", 64'(done_cnt - d0), 64'd1);
        chk("adc_a after busy trigs", adc_a, 14'h0F0F);
`ifdef ADC_CAPTURE_OVERRUN_EN
        chk("overrun sticky", ovr, 1'b1);
`endif

        // back-to-back: trig in first IDLE cycle after done
        next_a = 14'h1234; next_b = 14'h2345;
        pulse();
        wait_done(d1);
        @(negedge clk);
        next_a = 14'h3456; next_b = 14'h0567;
        pulse();
        wait_done(d2);
        chk("back-to-back spacing", 64'(d2 - d1), 64'd139);
        chk("b2b adc_a", adc_a, 14'h3456);
        @(negedge clk);

        // reset in the middle of bit 20
        next_a = 14'h1111; next_b = 14'h2222;
        t0 = cyc;
        pulse();
        while (cyc < t0 + 84) @(negedge clk);
        chk("bit20 sck high", sck, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst sck", sck, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst adc_a", adc_a, 14'h0000);
        chk("rst adc_b", adc_b, 14'h0000);
        d0 = done_cnt;
        repeat (150) @(negedge clk);
        chk("no done after rst", 64'(done_cnt - d0), 64'd0);
        do_frame(14'h2ABC, 14'h1555, 6'h3F);

        // randomized frames with random trig noise
        for (int k = 0; k < 10; k++) begin
            next_a = 14'($urandom); next_b = 14'($urandom); next_ign = 6'($urandom);
            pulse();
            for (int g = 0; g < int'($urandom_range(0, 160)); g++) begin
                trig = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            trig = 1'b0;
            repeat (150) @(negedge clk);
        end

        // SCK_DIV=1 instance
        tr = cyc; rises = 0; prev_rise = -1; spacing_ok = 1'b1; p1 = 1'b0; d0 = -1;
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sck1 && !p1) begin
                if (rises == 0) chk("div1 first rise", 64'(cyc - tr), 64'd3);
                else if (cyc - prev_rise != 2) spacing_ok = 1'b0;
                rises++;
                prev_rise = cyc;
            end
            p1 = sck1;
            if (done1) begin
                d0 = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("div1 done latency", 64'(d0 - tr), 64'd70);
        chk("div1 busy at done", busy1, 1'b1);
        chk("div1 adc_a", adc_a1, 14'h2ABC);
        chk("div1 adc_b", adc_b1, 14'h1555);
        chk("div1 sck rises", 64'(rises), 64'd34);
        chk("div1 sck period", 64'(spacing_ok), 64'd1);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
